// File: rtl/gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_ctrl
//  Description : Memory-mapped GPIO controller with configurable pin count,
//                input synchroniser, masked output update/toggle and
//                per-pin edge detection with sticky pending bits and a
//                single level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_ctrl #(
    parameter int                PIN         = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                ADDR_W      = 7,
    parameter logic [ADDR_W-1:0] BASE        = 7'h78
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [PIN-1:0]    gpio_in,
    output logic [PIN-1:0]    gpio_out,
    output logic [PIN-1:0]    gpio_oe,
    output logic              irq
);

    localparam int             CNT_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] C_WARM = CNT_W'(SYNC_STAGES + 1);

    localparam logic [2:0] C_DIR  = 3'd0;
    localparam logic [2:0] C_OUT  = 3'd1;
    localparam logic [2:0] C_MASK = 3'd2;
    localparam logic [2:0] C_IN   = 3'd3;
    localparam logic [2:0] C_RISE = 3'd4;
    localparam logic [2:0] C_FALL = 3'd5;
    localparam logic [2:0] C_PEND = 3'd6;
    localparam logic [2:0] C_TGL  = 3'd7;

    logic [PIN-1:0]   r_dir;
    logic [PIN-1:0]   r_out;
    logic [PIN-1:0]   r_mask;
    logic [PIN-1:0]   r_rise_en;
    logic [PIN-1:0]   r_fall_en;
    logic [PIN-1:0]   r_pend;
    logic [PIN-1:0]   r_prev;
    logic [PIN-1:0]   r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_warm;

    logic             w_hit;
    logic [2:0]       w_off;
    logic             w_wr;
    logic [PIN-1:0]   w_wd;
    logic [PIN-1:0]   w_in;
    logic [PIN-1:0]   w_set;
    logic [PIN-1:0]   w_clr;
    logic             w_unused;

    // Window decode: upper address bits must match the 8-aligned base
    assign w_hit    = (addr[ADDR_W-1:3] == BASE[ADDR_W-1:3]);
    assign w_off    = addr[2:0];
    assign w_wr     = we & w_hit;
    assign w_wd     = wdata[PIN-1:0];
    assign w_unused = ^wdata;

    assign w_in  = r_sync[SYNC_STAGES-1];
    // Edges are suppressed until the synchroniser and prev register hold real pin data
    assign w_set = (r_warm != '0) ? '0
                 : ((w_in & ~r_prev & r_rise_en) | (~w_in & r_prev & r_fall_en));
    assign w_clr = (w_wr && (w_off == C_PEND)) ? w_wd : '0;

    assign gpio_out = r_out & r_dir;
    assign gpio_oe  = r_dir;
    assign irq      = |r_pend;

    // Input synchroniser chain and previous-sample register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= w_in;
        end
    end

    // Warm-up counter: counts down to zero after reset, then holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm <= C_WARM;
        end else if (r_warm != '0) begin
            r_warm <= r_warm - 1'b1;
        end
    end

    // Control register writes, including masked OUT update and toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_mask    <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_off)
                C_DIR:   r_dir     <= w_wd;
                C_OUT:   r_out     <= (r_out & ~r_mask) | (w_wd & r_mask);
                C_MASK:  r_mask    <= w_wd;
                C_RISE:  r_rise_en <= w_wd;
                C_FALL:  r_fall_en <= w_wd;
                C_TGL:   r_out     <= r_out ^ (w_wd & r_mask);
                default: ;
            endcase
        end
    end

    // Sticky pending bits: a new edge wins over a same-cycle W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    // Combinational read mux; zero outside the window and above PIN-1
    always_comb begin
        rdata = '0;
        if (w_hit) begin
            case (w_off)
                C_DIR:   rdata[PIN-1:0] = r_dir;
                C_OUT:   rdata[PIN-1:0] = r_out;
                C_MASK:  rdata[PIN-1:0] = r_mask;
                C_IN:    rdata[PIN-1:0] = w_in;
                C_RISE:  rdata[PIN-1:0] = r_rise_en;
                C_FALL:  rdata[PIN-1:0] = r_fall_en;
                C_PEND:  rdata[PIN-1:0] = r_pend;
                default: rdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_ctrl
//  Description : Directed self-checking bench for gpio_ctrl (PIN=8 and PIN=4)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    logic [31:0] rdata4;
    logic [3:0]  gpio_in4;
    logic [3:0]  gpio_out4;
    logic [3:0]  gpio_oe4;
    logic        irq4;

    int errs;
    int checks;

    gpio_ctrl #(.PIN(8), .SYNC_STAGES(2), .ADDR_W(7), .BASE(7'h78)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_ctrl #(.PIN(4), .SYNC_STAGES(2), .ADDR_W(7), .BASE(7'h78)) u_dut4 (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata4), .gpio_in(gpio_in4), .gpio_out(gpio_out4),
        .gpio_oe(gpio_oe4), .irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge
    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        addr  = a;
        we    = 1'b1;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        errs     = 0;
        checks   = 0;
        rst      = 1'b1;
        addr     = 7'h00;
        we       = 1'b0;
        wdata    = 32'h0;
        gpio_in  = 8'h00;
        gpio_in4 = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and register map
        for (int i = 0; i < 8; i++) rd($sformatf("reset_reg%0d", i), 7'h78 + 7'(i), 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_oe", {24'h0, gpio_oe}, 32'h0);
        @(negedge clk);
        wr(7'h78, 32'hFF);
        wr(7'h7A, 32'h0F);
        wr(7'h79, 32'hAB);
        rd("out_masked", 7'h79, 32'h0B);
        check("gpio_out_0b", {24'h0, gpio_out}, 32'h0B);
        check("gpio_oe_ff", {24'h0, gpio_oe}, 32'hFF);

        // Masked RMW and toggle
        @(negedge clk);
        wr(7'h7A, 32'hF0);
        wr(7'h79, 32'h5A);
        rd("out_rmw", 7'h79, 32'h5B);
        @(negedge clk);
        wr(7'h7F, 32'hFF);
        rd("out_tgl", 7'h79, 32'hAB);
        rd("tgl_reads0", 7'h7F, 32'h0);
        @(negedge clk);
        wr(7'h78, 32'h0F);
        check("gpio_out_dir", {24'h0, gpio_out}, 32'h0B);
        check("gpio_oe_dir", {24'h0, gpio_oe}, 32'h0F);

        // Rising-edge latency
        @(negedge clk);
        wr(7'h7C, 32'h01);
        gpio_in = 8'h01;
        @(posedge clk); #1;
        rd("in_edge_n", 7'h7B, 32'h00);
        @(posedge clk); #1;
        rd("in_edge_n1", 7'h7B, 32'h01);
        rd("pend_edge_n1", 7'h7E, 32'h00);
        @(posedge clk); #1;
        rd("pend_edge_n2", 7'h7E, 32'h01);
        check("irq_edge_n2", {31'h0, irq}, 32'h1);

        // Falling edge with FALL_EN=0 leaves PEND alone
        @(negedge clk);
        gpio_in = 8'h00;
        repeat (4) @(negedge clk);
        rd("pend_fall_off", 7'h7E, 32'h01);

        // W1C and set-over-clear priority
        @(negedge clk);
        wr(7'h7C, 32'h03);
        gpio_in = 8'h02;
        repeat (4) @(negedge clk);
        rd("pend_03", 7'h7E, 32'h03);
        @(negedge clk);
        wr(7'h7E, 32'h01);
        rd("pend_w1c", 7'h7E, 32'h02);
        check("irq_w1c", {31'h0, irq}, 32'h1);
        @(negedge clk);
        gpio_in = 8'h00;
        repeat (4) @(negedge clk);
        gpio_in = 8'h02;       // edge n follows; PEND sets at edge n+2
        @(negedge clk);        // after edge n
        @(negedge clk);        // after edge n+1
        wr(7'h7E, 32'h02);     // W1C lands on edge n+2
        rd("pend_set_prio", 7'h7E, 32'h02);
        @(negedge clk);
        wr(7'h7E, 32'h02);
        rd("pend_cleared", 7'h7E, 32'h00);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Decode boundaries
        @(negedge clk);
        wr(7'h77, 32'hFF);
        wr(7'h00, 32'hFF);
        rd("rd_77", 7'h77, 32'h0);
        rd("rd_00", 7'h00, 32'h0);
        rd("dir_kept", 7'h78, 32'h0F);
        rd("out_kept", 7'h79, 32'hAB);
        rd("mask_kept", 7'h7A, 32'hF0);

        // Mid-operation reset and warm-up with pins held high
        @(negedge clk);
        gpio_in = 8'hFF;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr(7'h7C, 32'hFF);
        rd("rst_dir", 7'h78, 32'h0);
        rd("rst_out", 7'h79, 32'h0);
        @(negedge clk);
        repeat (10) @(negedge clk);
        rd("warm_pend", 7'h7E, 32'h0);
        check("warm_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        wr(7'h7D, 32'hFF);
        gpio_in = 8'h00;
        repeat (4) @(negedge clk);
        rd("fall_pend", 7'h7E, 32'hFF);
        check("fall_irq", {31'h0, irq}, 32'h1);

        // Narrow build: bits above PIN-1 read as zero
        @(negedge clk);
        wr(7'h78, 32'hFF);
        addr = 7'h78;
        #1;
        check("pin4_dir", rdata4, 32'h0F);
        check("pin4_oe", {28'h0, gpio_oe4}, 32'h0F);
        check("pin8_dir", rdata, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
